uart_rx_gen2: RTL and testbench
===============================

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data bits; legal 5..9.
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of prescale input.
REQ-003 SHALL have port CLK  in  1  sole clock; one clock; all logic on rising edge.
REQ-004 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port RX_IN  in  1  serial line, idle high, asynchronous to CLK.
REQ-006 SHALL have port prescale  in  PRESCALE_W  CLK cycles per bit.
REQ-007 SHALL have port PAR_EN  in  1  parity bit present.
REQ-008 SHALL have port PAR_TYP  in  1  0 = even, 1 = odd.
REQ-009 SHALL have port STP2_EN  in  1  two stop bits expected.
REQ-010 SHALL have port P_DATA  out  DATA_WIDTH  received word, LSB first on line.
REQ-011 SHALL have port data_valid  out  1  one-cycle pulse, P_DATA valid.
REQ-012 SHALL have ports par_err, stp_err, strt_glitch  out  1 each  one-cycle error pulses.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL pass RX_IN through a 2-flop synchroniser; all references to RX below mean the synchronised value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-016 SHALL leave IDLE on a 1->0 transition of RX.
REQ-017 SHALL latch prescale, PAR_EN, PAR_TYP and STP2_EN on leaving IDLE; changes mid-frame have no effect.
REQ-018 SHALL clamp latched prescale values below 4 to 4.
REQ-019 SHALL count edges 0..prescale-1 per bit, wrapping to 0 and advancing the bit counter.
REQ-020 SHALL sample each bit as the majority of the RX values at edges P/2-1, P/2 and P/2+1 (P = latched prescale, integer division).
REQ-021 SHALL return to IDLE from START when the start-bit majority is 1, and pulse strt_glitch.
REQ-022 SHALL shift DATA_WIDTH bits LSB first in DATA, then go to PARITY if PAR_EN, else STOP1.
REQ-023 SHALL flag a parity error when XOR(data, parity bit) differs from PAR_TYP.
REQ-024 SHALL decide the frame at the majority point of the last stop bit (STOP1, or STOP2 if STP2_EN), then enter IDLE the next cycle without waiting for the bit end, so back-to-back frames are received.
REQ-025 SHALL take the stop bit as a stop error when any sampled stop bit is 0.
REQ-026 SHALL, on a frame with no error, update P_DATA and pulse data_valid one cycle after the final sample.
REQ-027 SHALL, on a parity or stop error, pulse the matching error flag(s) in that same cycle, suppress data_valid and leave P_DATA unchanged.
REQ-028 SHALL allow par_err and stp_err to pulse together.
REQ-029 SHALL hold P_DATA between frames.

Reset
REQ-030 SHALL, while RST is high at a clock edge, set the state to IDLE, clear the counters and synchroniser (to 1), set P_DATA=0, and drive data_valid, par_err, stp_err, strt_glitch and busy to 0.
REQ-031 SHALL abandon a frame in progress when RST is asserted, with no pulse emitted.

Configuration
REQ-032 SHALL compile break detection only when macro UART_RX_BREAK_DET_EN is defined.
REQ-033 SHALL, with UART_RX_BREAK_DET_EN defined, add port break_det (out, 1).
REQ-034 SHALL, with UART_RX_BREAK_DET_EN defined and all data bits, parity (if any) and stop bits sampled 0, pulse break_det instead of stp_err and par_err.
REQ-035 SHALL, after such a break, wait in IDLE-blocked mode until RX is 1 before accepting a new start.
REQ-036 SHALL, without UART_RX_BREAK_DET_EN, omit the break_det port and report an all-zero frame as stp_err.

Structure
REQ-037 SHALL place the state enum typedef and the minimum-prescale constant (4) in shared package uart_rx_pkg.
REQ-038 SHALL implement the edge counter and majority-vote sampler as sub-module uart_rx_sampler.

Verification
REQ-039 SHALL cover: prescale=8, PAR_EN=1, even parity, byte 0xA5 -> P_DATA=0xA5, one data_valid pulse, no error flags.
REQ-040 SHALL cover: prescale=16, odd parity, 0x3C sent with a wrong parity bit -> par_err pulse, no data_valid, P_DATA holds its previous value.
REQ-041 SHALL cover: prescale=16, RX low for 4 cycles then high -> strt_glitch pulse, busy returns to 0, no data_valid.
REQ-042 SHALL cover: DATA_WIDTH=7, STP2_EN=1, frames 0x55 and 0x2A back-to-back with zero idle -> two data_valid pulses with those values.
REQ-043 SHALL cover: stop bit driven 0 -> stp_err pulse; all-zero frame -> break_det when the macro is defined, stp_err when it is not.
REQ-044 SHALL cover: RST asserted in the middle of DATA -> all outputs 0 the next cycle, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver state encoding, minimum prescale and majority helper
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_t;

    localparam int MIN_PRESCALE = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with 3-point majority vote around the bit centre
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] p,
    output logic                  mid,
    output logic                  bit_end,
    output logic                  vote
);

    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  s0;
    logic                  s1;

    assign half    = p >> 1;
    assign mid     = en && (cnt == half + 1'b1);
    assign bit_end = en && (cnt == p - 1'b1);
    assign vote    = maj3(s0, s1, rx);

    // count edges within a bit and capture the two samples preceding the vote point
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
        if (rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (cnt == half - 1'b1) s0 <= rx;
            if (cnt == half) s1 <= rx;
        end
    end

endmodule

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: oversampled UART receiver; break detection built when UART_RX_BREAK_DET_EN is defined
module uart_rx_gen2
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP2_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                  break_det
`endif
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(MIN_PRESCALE);

    rx_state_t             state;
    logic [1:0]            rx_sync;
    logic                  rx;
    logic                  rx_prev;
    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] p_clamp;
    logic [PRESCALE_W-1:0] p_sel;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  stp2_l;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic                  par_bit;
    logic                  stp_bad;
    logic                  fall;
    logic                  mid;
    logic                  bit_end;
    logic                  vote;
    logic                  last_stop;
    logic                  stop_bad;
    logic                  par_bad;
`ifdef UART_RX_BREAK_DET_EN
    logic                  brk_hold;
    logic                  all_zero;
`endif

    assign rx        = rx_sync[1];
    assign busy      = state != IDLE;
    assign p_clamp   = (prescale < P_MIN) ? P_MIN : prescale;
    assign p_sel     = busy ? p_lat : p_clamp;
    assign last_stop = mid && ((state == STOP1 && !stp2_l) || state == STOP2);
    assign stop_bad  = !vote || (state == STOP2 && stp_bad);
    assign par_bad   = par_en_l && ((^sr ^ par_bit) != par_typ_l);
`ifdef UART_RX_BREAK_DET_EN
    assign fall      = rx_prev && !rx && !brk_hold;
    assign all_zero  = (sr == '0) && !(par_en_l && par_bit) && !vote && (state != STOP2 || stp_bad);
`else
    assign fall      = rx_prev && !rx;
`endif

    // the detection cycle is edge 0 of the start bit, so the counter runs from the fall onward
    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk     (CLK),
        .rst     (RST),
        .en      (busy || fall),
        .rx      (rx),
        .p       (p_sel),
        .mid     (mid),
        .bit_end (bit_end),
        .vote    (vote)
    );

    // two-flop synchroniser plus previous value for start-edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], RX_IN};
            rx_prev <= rx;
        end
    end

    // frame FSM: bit sequencing, shift register, frame decision and registered pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            p_lat       <= '0;
            par_en_l    <= 1'b0;
            par_typ_l   <= 1'b0;
            stp2_l      <= 1'b0;
            bit_cnt     <= '0;
            sr          <= '0;
            par_bit     <= 1'b0;
            stp_bad     <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det   <= 1'b0;
            brk_hold    <= 1'b0;
`endif
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det   <= 1'b0;
            if (state == IDLE && rx) brk_hold <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        state     <= START;
                        p_lat     <= p_clamp;
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        stp2_l    <= STP2_EN;
                        bit_cnt   <= '0;
                        stp_bad   <= 1'b0;
                    end
                end
                START: begin
                    if (mid && vote) begin
                        state       <= IDLE;
                        strt_glitch <= 1'b1;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (mid) sr <= {vote, sr[DATA_WIDTH-1:1]};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= par_en_l ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (mid) par_bit <= vote;
                    if (bit_end) state <= STOP1;
                end
                STOP1, STOP2: begin
                    if (last_stop) begin
                        state <= IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        if (all_zero) begin
                            break_det <= 1'b1;
                            brk_hold  <= 1'b1;
                        end else
`endif
                        begin
                            par_err <= par_bad;
                            stp_err <= stop_bad;
                            if (!par_bad && !stop_bad) begin
                                data_valid <= 1'b1;
                                P_DATA     <= sr;
                            end
                        end
                    end else begin
                        if (mid) stp_bad <= !vote;
                        if (bit_end) state <= STOP2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: directed self-checking bench for uart_rx_gen2 (8-bit and 7-bit instances)
module tb_uart_rx_gen2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stp2 = 1'b0;
    logic [7:0] pd8;
    logic [6:0] pd7;
    logic       dv8, pe8, se8, sg8, bz8;
    logic       dv7, pe7, se7, sg7, bz7;
`ifdef UART_RX_BREAK_DET_EN
    logic       bk8, bk7;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int c_dv8 = 0, c_pe8 = 0, c_se8 = 0, c_sg8 = 0, c_bk8 = 0;
    int c_dv7 = 0, c_se7 = 0;
    int b_dv8, b_pe8, b_se8, b_sg8, b_bk8, b_dv7, b_se7;
    logic [6:0] q7[$];

    always #5 clk = ~clk;

    uart_rx_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(6)) u8 (
        .CLK(clk), .RST(rst), .RX_IN(rx8), .prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STP2_EN(stp2), .P_DATA(pd8), .data_valid(dv8),
        .par_err(pe8), .stp_err(se8), .strt_glitch(sg8), .busy(bz8)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(bk8)
`endif
    );

    uart_rx_gen2 #(.DATA_WIDTH(7), .PRESCALE_W(6)) u7 (
        .CLK(clk), .RST(rst), .RX_IN(rx7), .prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STP2_EN(stp2), .P_DATA(pd7), .data_valid(dv7),
        .par_err(pe7), .stp_err(se7), .strt_glitch(sg7), .busy(bz7)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(bk7)
`endif
    );

    // pulse counters sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (dv8) c_dv8++;
        if (pe8) c_pe8++;
        if (se8) c_se8++;
        if (sg8) c_sg8++;
`ifdef UART_RX_BREAK_DET_EN
        if (bk8) c_bk8++;
`endif
        if (se7) c_se7++;
        if (dv7) begin
            c_dv7++;
            q7.push_back(pd7);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_dv8 = c_dv8; b_pe8 = c_pe8; b_se8 = c_se8; b_sg8 = c_sg8; b_bk8 = c_bk8;
        b_dv7 = c_dv7; b_se7 = c_se7;
    endtask

    task automatic hold(input int sel, input logic v, input int p);
        if (sel == 7) rx7 = v;
        else rx8 = v;
        repeat (p) @(negedge clk);
    endtask

    task automatic send(input int sel, input int p, input int n, input logic [8:0] d,
                        input logic pen, input logic ptyp, input logic flip,
                        input int nstop, input logic sv);
        logic par;
        par = ptyp ^ flip;
        hold(sel, 1'b0, p);
        for (int i = 0; i < n; i++) begin
            hold(sel, d[i], p);
            par ^= d[i];
        end
        if (pen) hold(sel, par, p);
        for (int i = 0; i < nstop; i++) hold(sel, sv, p);
        if (sel == 7) rx7 = 1'b1;
        else rx8 = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pdata", int'(pd8), 0);
        check("rst_dv", int'(dv8), 0);
        check("rst_pe", int'(pe8), 0);
        check("rst_se", int'(se8), 0);
        check("rst_sg", int'(sg8), 0);
        check("rst_busy", int'(bz8), 0);
        check("rst_pdata7", int'(pd7), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stp2 = 1'b0;
        snap();
        send(8, 8, 8, 9'h0A5, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        repeat (6) @(negedge clk);
        check("a5_dv", c_dv8 - b_dv8, 1);
        check("a5_data", int'(pd8), 'hA5);
        check("a5_pe", c_pe8 - b_pe8, 0);
        check("a5_se", c_se8 - b_se8, 0);
        check("a5_busy", int'(bz8), 0);

        prescale = 6'd16; par_typ = 1'b1;
        snap();
        send(8, 16, 8, 9'h03C, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        repeat (6) @(negedge clk);
        check("par_pe", c_pe8 - b_pe8, 1);
        check("par_dv", c_dv8 - b_dv8, 0);
        check("par_se", c_se8 - b_se8, 0);
        check("par_hold", int'(pd8), 'hA5);

        snap();
        rx8 = 1'b0;
        repeat (4) @(negedge clk);
        rx8 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_sg", c_sg8 - b_sg8, 1);
        check("glitch_busy", int'(bz8), 0);
        check("glitch_dv", c_dv8 - b_dv8, 0);

        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stp2 = 1'b1;
        snap();
        q7.delete();
        send(7, 8, 7, 9'h055, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        send(7, 8, 7, 9'h02A, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        repeat (6) @(negedge clk);
        check("b2b_dv", c_dv7 - b_dv7, 2);
        check("b2b_se", c_se7 - b_se7, 0);
        check("b2b_qsize", q7.size(), 2);
        if (q7.size() >= 2) begin
            check("b2b_first", int'(q7[0]), 'h55);
            check("b2b_second", int'(q7[1]), 'h2A);
        end

        stp2 = 1'b0;
        snap();
        send(8, 8, 8, 9'h012, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        repeat (6) @(negedge clk);
        check("stop_se", c_se8 - b_se8, 1);
        check("stop_dv", c_dv8 - b_dv8, 0);
        check("stop_hold", int'(pd8), 'hA5);

        snap();
        send(8, 8, 8, 9'h000, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        repeat (6) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
        check("brk_det", c_bk8 - b_bk8, 1);
        check("brk_se", c_se8 - b_se8, 0);
`else
        check("zero_se", c_se8 - b_se8, 1);
`endif
        check("zero_dv", c_dv8 - b_dv8, 0);

        prescale = 6'd2;
        snap();
        send(8, 4, 8, 9'h081, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        repeat (6) @(negedge clk);
        check("clamp_dv", c_dv8 - b_dv8, 1);
        check("clamp_data", int'(pd8), 'h81);

        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        snap();
        hold(8, 1'b0, 8);
        hold(8, 1'b1, 8);
        hold(8, 1'b1, 8);
        hold(8, 1'b1, 4);
        check("mid_busy", int'(bz8), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_pdata", int'(pd8), 0);
        check("mrst_busy", int'(bz8), 0);
        check("mrst_dv", int'(dv8), 0);
        check("mrst_pe", int'(pe8), 0);
        check("mrst_se", int'(se8), 0);
        check("mrst_sg", int'(sg8), 0);
        rst = 1'b0;
        hold(8, 1'b1, 30);
        check("mrst_nodv", c_dv8 - b_dv8, 0);
        check("mrst_noerr", (c_pe8 - b_pe8) + (c_se8 - b_se8) + (c_sg8 - b_sg8), 0);
        snap();
        send(8, 8, 8, 9'h096, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        repeat (6) @(negedge clk);
        check("post_dv", c_dv8 - b_dv8, 1);
        check("post_data", int'(pd8), 'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
